store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - FIFO of committed stores between the MEM-stage store path and the byte-addressed data memory.
// - Accepts one store per cycle and drains the oldest store to memory whenever the memory port is idle.
// - Flags younger loads that may overlap a buffered store so the pipeline stalls them.
// - Drives the data memory's MemWrite/SizeSrc/WriteData/ALUResult inputs on the store path.
// PARAMETERS
// - DEPTH      4   entries; power of two, >= 2
// - ADDR_BITS  17  address bits used for matching; equals data memory address width
// PORTS
// - clk           in   1   rising-edge clock
// - rst_n         in   1   reset; asynchronous, active-low
// - StoreValid    in   1   store request this cycle
// - StoreAddr     in   32  store byte address
// - StoreData     in   32  store data; low bytes used for sh/sb
// - StoreSize     in   2   00 word, 01 half, 10 byte (SizeSrc encoding); 11 illegal
// - StoreReady    out  1   buffer can accept a store this cycle
// - LoadValid     in   1   load request this cycle
// - LoadAddr      in   32  load byte address
// - LoadSize      in   2   SizeSrc encoding of the load
// - LoadStall     out  1   load must be held; combinational
// - FwdValid      out  1   forwarded data valid (STORE_BUF_FWD_EN only)
// - FwdData       out  32  forwarded load data
// - MemBusy       in   1   memory port used by a load this cycle; no drain
// - MemWrite      out  1   drain strobe to data memory
// - MemAddr       out  32  drain address (to ALUResult)
// - MemWriteData  out  32  drain data
// - MemSize       out  2   drain size (to SizeSrc)
// - Empty         out  1   no valid entries
// - Count         out  $clog2(DEPTH)+1  number of valid entries
// BEHAVIOUR
// - Storage: circular array, head/tail pointers $clog2(DEPTH) bits wrapping mod DEPTH, plus registered Count.
// - Reset (async, rst_n=0): Count=0, head=tail=0, all valid bits 0.
//   Outputs: Empty=1, StoreReady=1, MemWrite=0, LoadStall=0, FwdValid=0. Entry payload is not reset.
// - Push: StoreValid && StoreReady at posedge writes {addr,data,size} at tail; tail++.
//   StoreReady = (Count != DEPTH). No bypass when full, even if a pop occurs the same cycle.
// - Pop: MemWrite = !Empty && !MemBusy (combinational). Mem* outputs show the head entry.
//   Mem* outputs are 0 when Empty. MemWrite at posedge pops the head (head++); the memory writes the same edge.
// - Push and pop in the same cycle: Count unchanged, FIFO order kept. Otherwise Count +/-1.
// - Latency: a store pushed at edge N can drain at edge N+1 at the earliest.
// - StoreSize=11: entry accepted and drained with MemSize=11; the memory ignores it.
// - Hazard: entry e matches when valid and |e.addr[ADDR_BITS-1:2] - LoadAddr[ADDR_BITS-1:2]| <= 1.
//   Compare mod 2^(ADDR_BITS-2). Conservative, covers unaligned spans.
// - LoadStall = LoadValid && (any entry matches) && !FwdValid. The load stage keeps MemBusy=0 while stalled.
// - The entry popped this cycle still counts for hazard detection. The entry pushed this cycle does not.
// - No flush: committed stores always drain. A reset mid-drain discards all entries.
// CONFIGURATION
// - STORE_BUF_FWD_EN defined: FwdValid=1 and LoadStall=0 when all of the following hold:
//   - LoadValid=1, LoadSize=00, LoadAddr[1:0]=00;
//   - exactly one entry matches;
//   - that entry has size 00 and addr[ADDR_BITS-1:0] == LoadAddr[ADDR_BITS-1:0].
//   Then FwdData = that entry's data. Otherwise FwdValid=0 and FwdData=0.
// - STORE_BUF_FWD_EN undefined: FwdValid tied 0, FwdData tied 0, every hazard stalls.
// TESTING
// - Reset: rst_n=0 -> Empty=1, Count=0, StoreReady=1, MemWrite=0, LoadStall=0.
// - Fill: MemBusy=1, push 4 sw at 0x00,0x04,0x08,0x0C -> Count=4, StoreReady=0, 5th push dropped.
//   Then MemBusy=0 -> MemWrite on 4 consecutive cycles, addresses 0x00..0x0C in order, then Empty=1.
// - Hazard: MemBusy=1, sw 0x100 data 0xDEADBEEF buffered.
//   lw 0x104 -> LoadStall=1; lb 0x0FF -> LoadStall=1; lw 0x10C -> LoadStall=0.
// - Push+pop at Count=2 with MemBusy=0 -> Count stays 2, drained address = oldest entry.
// - Async reset mid-drain at Count=3 -> Count=0, MemWrite=0 before the next clk edge.
// - STORE_BUF_FWD_EN: sw 0x200 data 0x12345678 buffered.
//   lw 0x200 -> FwdValid=1, FwdData=0x12345678, LoadStall=0. lh 0x200 -> LoadStall=1, FwdValid=0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores sitting between the MEM-stage store
// path and the byte-addressed data memory. It accepts one store per cycle and
// drains the oldest entry whenever the memory port is not used by a load. It
// also flags younger loads that may overlap a buffered store, so the pipeline
// can stall them.
//
// Optional feature: define STORE_BUF_FWD_EN to forward data from a buffered
// aligned word store to an aligned word load with the same address. When the
// macro is undefined, FwdValid/FwdData are tied to 0 and every hazard stalls.
//
// DEPTH must be a power of two and at least 2. ADDR_BITS (below 32) is the
// data memory address width and sets how many address bits are compared.

module store_buffer #(
   parameter int DEPTH     = 4,
   parameter int ADDR_BITS = 17
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     StoreValid,
   input  logic [31:0]              StoreAddr,
   input  logic [31:0]              StoreData,
   input  logic [1:0]               StoreSize,
   output logic                     StoreReady,
   input  logic                     LoadValid,
   input  logic [31:0]              LoadAddr,
   input  logic [1:0]               LoadSize,
   output logic                     LoadStall,
   output logic                     FwdValid,
   output logic [31:0]              FwdData,
   input  logic                     MemBusy,
   output logic                     MemWrite,
   output logic [31:0]              MemAddr,
   output logic [31:0]              MemWriteData,
   output logic [1:0]               MemSize,
   output logic                     Empty,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WORD_W = ADDR_BITS - 2;

   // Entry payload (not reset) and per-entry valid bits
   logic [31:0]       entryAddr_q [DEPTH];
   logic [31:0]       entryData_q [DEPTH];
   logic [1:0]        entrySize_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;

   // Circular pointers and occupancy
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              doPush;
   logic              doPop;

   // Hazard detection results
   logic [WORD_W-1:0] wordDiff [DEPTH];
   logic [DEPTH-1:0]  entryMatch;
   logic              anyMatch;

   logic              unusedLoadBits;

   // Occupancy flags: a full buffer refuses stores even if it drains this cycle
   assign Empty      = (count_q == '0);
   assign StoreReady = (count_q != CNT_W'(DEPTH));
   assign Count      = count_q;

   // The head drains whenever there is something to write and no load owns the port
   assign MemWrite = !Empty && !MemBusy;
   assign doPush   = StoreValid && StoreReady;
   assign doPop    = MemWrite;

   // Drain port shows the head entry, zeroed while the buffer is empty
   assign MemAddr      = Empty ? 32'h0 : entryAddr_q[head_q];
   assign MemWriteData = Empty ? 32'h0 : entryData_q[head_q];
   assign MemSize      = Empty ? 2'b00 : entrySize_q[head_q];

   // Next-state for pointers, valid bits and count from this cycle's push/pop
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (doPush) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      if (doPop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset empties the buffer without touching payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload write at the tail on an accepted store
   always_ff @(posedge clk) begin
      if (doPush) begin
         entryAddr_q[tail_q] <= StoreAddr;
         entryData_q[tail_q] <= StoreData;
         entrySize_q[tail_q] <= StoreSize;
      end
   end

   // Conservative overlap test: word addresses within one of each other,
   // wrapping modulo the word-address space, so unaligned spans are covered
   always_comb begin
      entryMatch = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wordDiff[i]   = entryAddr_q[i][ADDR_BITS-1:2] - LoadAddr[ADDR_BITS-1:2];
         entryMatch[i] = valid_q[i] &&
                         ((wordDiff[i] == WORD_W'(0)) ||
                          (wordDiff[i] == WORD_W'(1)) ||
                          (wordDiff[i] == {WORD_W{1'b1}}));
      end
   end

   assign anyMatch = |entryMatch;

`ifdef STORE_BUF_FWD_EN
   logic [CNT_W-1:0] matchCount;
   logic [PTR_W-1:0] matchIdx;
   logic             fwdHit;

   // Count matching entries and remember which one, for the single-match forward case
   always_comb begin
      matchCount = '0;
      matchIdx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryMatch[i]) begin
            matchCount = matchCount + CNT_W'(1);
            matchIdx   = PTR_W'(i);
         end
      end
   end

   // Forward only an exact aligned word-to-word hit with no other overlapping store
   always_comb begin
      fwdHit = LoadValid &&
               (LoadSize == 2'b00) &&
               (LoadAddr[1:0] == 2'b00) &&
               (matchCount == CNT_W'(1)) &&
               (entrySize_q[matchIdx] == 2'b00) &&
               (entryAddr_q[matchIdx][ADDR_BITS-1:0] == LoadAddr[ADDR_BITS-1:0]);
   end

   assign FwdValid       = fwdHit;
   assign FwdData        = fwdHit ? entryData_q[matchIdx] : 32'h0;
   assign unusedLoadBits = ^LoadAddr[31:ADDR_BITS];
`else
   assign FwdValid       = 1'b0;
   assign FwdData        = 32'h0;
   assign unusedLoadBits = ^{LoadAddr[31:ADDR_BITS], LoadAddr[1:0], LoadSize};
`endif

   // Any overlapping buffered store holds the load unless it can be forwarded
   assign LoadStall = LoadValid && anyMatch && !FwdValid;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic for store_buffer.
// A queue-based reference model predicts occupancy, drain port and hazard
// outputs; drained stores are checked by a monitor against a scoreboard queue.
// Define STORE_BUF_FWD_EN for both RTL and bench to exercise forwarding.

module tb_store_buffer;

   localparam int DEPTH     = 4;
   localparam int ADDR_BITS = 17;
   localparam int WORDS     = 1 << (ADDR_BITS - 2);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        StoreValid;
   logic [31:0] StoreAddr;
   logic [31:0] StoreData;
   logic [1:0]  StoreSize;
   logic        StoreReady;
   logic        LoadValid;
   logic [31:0] LoadAddr;
   logic [1:0]  LoadSize;
   logic        LoadStall;
   logic        FwdValid;
   logic [31:0] FwdData;
   logic        MemBusy;
   logic        MemWrite;
   logic [31:0] MemAddr;
   logic [31:0] MemWriteData;
   logic [1:0]  MemSize;
   logic        Empty;
   logic [2:0]  Count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } storeEntry_t;

   storeEntry_t bufModel[$];
   storeEntry_t expDrain[$];

   int nCompared   = 0;
   int nMismatched = 0;

   store_buffer #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .StoreValid   (StoreValid),
      .StoreAddr    (StoreAddr),
      .StoreData    (StoreData),
      .StoreSize    (StoreSize),
      .StoreReady   (StoreReady),
      .LoadValid    (LoadValid),
      .LoadAddr     (LoadAddr),
      .LoadSize     (LoadSize),
      .LoadStall    (LoadStall),
      .FwdValid     (FwdValid),
      .FwdData      (FwdData),
      .MemBusy      (MemBusy),
      .MemWrite     (MemWrite),
      .MemAddr      (MemAddr),
      .MemWriteData (MemWriteData),
      .MemSize      (MemSize),
      .Empty        (Empty),
      .Count        (Count)
   );

   // Free-running clock, 20 time units per period
   always #10 clk = ~clk;

   task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Two byte addresses overlap-candidates when their word indices differ by at most one (wrapping)
   function automatic bit wordNear(input logic [31:0] a, input logic [31:0] b);
      int wa, wb, d;
      wa = int'(a[ADDR_BITS-1:2]);
      wb = int'(b[ADDR_BITS-1:2]);
      d  = ((wa - wb) % WORDS + WORDS) % WORDS;
      return (d <= 1) || (d == WORDS - 1);
   endfunction

   task automatic driveIdle(input bit busy);
      StoreValid = 1'b0;
      StoreAddr  = '0;
      StoreData  = '0;
      StoreSize  = 2'b00;
      LoadValid  = 1'b0;
      LoadAddr   = '0;
      LoadSize   = 2'b00;
      MemBusy    = busy;
   endtask

   // Compare every output against what the reference model predicts right now
   task automatic checkOutput();
      int          n, nMatch, hit;
      bit          empty, fwd;
      logic [31:0] fdata, eAddr, eData;
      logic [1:0]  eSize;
      n      = bufModel.size();
      empty  = (n == 0);
      eAddr  = '0;
      eData  = '0;
      eSize  = '0;
      if (!empty) begin
         eAddr = bufModel[0].addr;
         eData = bufModel[0].data;
         eSize = bufModel[0].size;
      end
      compareVal("Empty", Empty, empty);
      compareVal("Count", Count, n);
      compareVal("StoreReady", StoreReady, n != DEPTH);
      compareVal("MemWrite", MemWrite, !empty && !MemBusy);
      compareVal("MemAddr", MemAddr, eAddr);
      compareVal("MemWriteData", MemWriteData, eData);
      compareVal("MemSize", MemSize, eSize);
      nMatch = 0;
      hit    = 0;
      foreach (bufModel[i]) begin
         if (wordNear(bufModel[i].addr, LoadAddr)) begin
            nMatch++;
            hit = i;
         end
      end
      fwd   = 1'b0;
      fdata = '0;
`ifdef STORE_BUF_FWD_EN
      if (LoadValid && LoadSize == 2'b00 && LoadAddr[1:0] == 2'b00 && nMatch == 1 &&
          bufModel[hit].size == 2'b00 &&
          bufModel[hit].addr[ADDR_BITS-1:0] == LoadAddr[ADDR_BITS-1:0]) begin
         fwd   = 1'b1;
         fdata = bufModel[hit].data;
      end
`endif
      compareVal("FwdValid", FwdValid, fwd);
      compareVal("FwdData", FwdData, fdata);
      compareVal("LoadStall", LoadStall, LoadValid && nMatch > 0 && !fwd);
   endtask

   // Drive one cycle of inputs on the falling edge, then check combinational outputs
   task automatic applyStimulus(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [1:0] ss, input bit lv, input logic [31:0] la,
                                input logic [1:0] ls, input bit busy);
      @(negedge clk);
      StoreValid = sv;
      StoreAddr  = sa;
      StoreData  = sd;
      StoreSize  = ss;
      LoadValid  = lv;
      LoadAddr   = la;
      LoadSize   = ls;
      MemBusy    = busy;
      #1;
      checkOutput();
   endtask

   // Rising edge: the model accepts/drains by the behavioural rules
   task automatic advanceClock();
      bit          accept, drain;
      storeEntry_t e;
      @(posedge clk);
      if (!rst_n) begin
         bufModel.delete();
         expDrain.delete();
      end else begin
         accept = StoreValid && (bufModel.size() < DEPTH);
         drain  = (bufModel.size() > 0) && !MemBusy;
         if (drain) void'(bufModel.pop_front());
         if (accept) begin
            e.addr = StoreAddr;
            e.data = StoreData;
            e.size = StoreSize;
            bufModel.push_back(e);
            expDrain.push_back(e);
         end
      end
   endtask

   task automatic doCycle(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic [1:0] ss, input bit lv, input logic [31:0] la,
                          input logic [1:0] ls, input bit busy);
      applyStimulus(sv, sa, sd, ss, lv, la, ls, busy);
      advanceClock();
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] hi, off;
      hi = $urandom() & 32'hFFFE_0000;
      case ($urandom_range(0, 2))
         0:       off = 32'h100 + $urandom_range(0, 47);
         1:       off = $urandom_range(0, 31);
         default: off = 32'h1FFE0 + $urandom_range(0, 31);
      endcase
      return hi | off;
   endfunction

   // Drain monitor: every strobe must present the oldest outstanding store
   initial begin
      storeEntry_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && MemWrite) begin
            if (expDrain.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL drainOrder: got strobe at 0x%08h, expected no pending store", MemAddr);
            end else begin
               e = expDrain.pop_front();
               compareVal("drainAddr", MemAddr, e.addr);
               compareVal("drainData", MemWriteData, e.data);
               compareVal("drainSize", MemSize, e.size);
            end
         end
      end
   end

   // Directed scenarios, then randomized traffic, then final drain and summary
   initial begin
      bit          sv, lv, busy;
      logic [31:0] sa, sd, la;
      logic [1:0]  ss, ls;

      driveIdle(1'b0);
      rst_n = 1'b0;
      #2;
      compareVal("rstEmpty", Empty, 1);
      compareVal("rstCount", Count, 0);
      compareVal("rstStoreReady", StoreReady, 1);
      compareVal("rstMemWrite", MemWrite, 0);
      compareVal("rstLoadStall", LoadStall, 0);
      compareVal("rstFwdValid", FwdValid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] fill and drain");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
         if (i == 4) begin
            compareVal("fullCount", Count, 4);
            compareVal("fullStoreReady", StoreReady, 0);
         end
         advanceClock();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);
         compareVal("fillDrainStrobe", MemWrite, 1);
         compareVal("fillDrainAddr", MemAddr, 32'(i * 4));
         advanceClock();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);
      compareVal("drainedEmpty", Empty, 1);
      advanceClock();

      $display("[TB] hazard window");
      doCycle(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h104, 2'b00, 1'b1);
      compareVal("hazNextWord", LoadStall, 1);
      advanceClock();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0FF, 2'b10, 1'b1);
      compareVal("hazPrevByte", LoadStall, 1);
      advanceClock();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h10C, 2'b00, 1'b1);
      compareVal("hazFar", LoadStall, 0);
      advanceClock();
      repeat (2) doCycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);

      $display("[TB] simultaneous push and pop");
      doCycle(1'b1, 32'h300, 32'h1111_0000, 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
      doCycle(1'b1, 32'h304, 32'h2222_0000, 2'b01, 1'b0, 32'h0, 2'b00, 1'b1);
      applyStimulus(1'b1, 32'h308, 32'h3333_0000, 2'b11, 1'b0, 32'h0, 2'b00, 1'b0);
      compareVal("ppStrobe", MemWrite, 1);
      compareVal("ppOldest", MemAddr, 32'h300);
      advanceClock();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
      compareVal("ppCount", Count, 2);
      compareVal("ppNextHead", MemAddr, 32'h304);
      advanceClock();
      repeat (3) doCycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);

      $display("[TB] reset during drain");
      for (int i = 0; i < 3; i++)
         doCycle(1'b1, 32'h400 + 32'(i * 4), 32'h4400_0000 + 32'(i), 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);
      compareVal("preRstStrobe", MemWrite, 1);
      #3;
      rst_n = 1'b0;
      #1;
      compareVal("midRstCount", Count, 0);
      compareVal("midRstMemWrite", MemWrite, 0);
      compareVal("midRstEmpty", Empty, 1);
      compareVal("midRstStoreReady", StoreReady, 1);
      bufModel.delete();
      expDrain.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] forwarding");
      doCycle(1'b1, 32'h200, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 2'b00, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h200, 2'b00, 1'b1);
`ifdef STORE_BUF_FWD_EN
      compareVal("fwdWordValid", FwdValid, 1);
      compareVal("fwdWordData", FwdData, 32'h1234_5678);
      compareVal("fwdWordStall", LoadStall, 0);
`else
      compareVal("noFwdWordStall", LoadStall, 1);
      compareVal("noFwdWordValid", FwdValid, 0);
`endif
      advanceClock();
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h200, 2'b01, 1'b1);
      compareVal("fwdHalfStall", LoadStall, 1);
      compareVal("fwdHalfValid", FwdValid, 0);
      advanceClock();
      repeat (2) doCycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         sv   = ($urandom_range(0, 99) < 55);
         ss   = 2'($urandom_range(0, 3));
         sa   = randAddr();
         if ($urandom_range(0, 99) < 70) sa[1:0] = 2'b00;
         sd   = $urandom();
         lv   = ($urandom_range(0, 99) < 60);
         ls   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
         la   = ($urandom_range(0, 2) == 0 && bufModel.size() > 0) ?
                bufModel[$urandom_range(0, bufModel.size() - 1)].addr : randAddr();
         if ($urandom_range(0, 99) < 70) la[1:0] = 2'b00;
         busy = ($urandom_range(0, 99) < 40);
         doCycle(sv, sa, sd, ss, lv, la, ls, busy);
      end

      repeat (DEPTH + 2) doCycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0);
      compareVal("finalEmpty", Empty, 1);
      compareVal("finalPending", expDrain.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
